// File: rtl/key_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module      : key_fifo_writer
// Description : Debounces an active-low push-button and, on each press,
//               writes a burst of up to BURST_LEN incrementing bytes into a
//               FIFO, stopping early (no retry) if the FIFO reports full.
// Revision    : 1.0 - initial release
// ============================================================================
module key_fifo_writer #(
  parameter int DEBOUNCE_CYC = 20,
  parameter int BURST_LEN    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  input  logic       wrfull,
  input  logic       wrempty,
  output logic [7:0] data,
  output logic       wrreq,
  output logic       led_wr
);

  localparam int            STAB_W     = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]    BURST_LAST = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic              key_meta_q;
  logic              key_sync_q;
  logic [STAB_W-1:0] stab_cnt_q;
  logic [STAB_W-1:0] stab_cnt_d;
  logic              key_db_q;
  logic              key_db_dly_q;
  logic              press;
  state_t            state_q;
  logic              led_q;
  logic [7:0]        data_q;
  logic [7:0]        data_d;
  logic [7:0]        burst_cnt_q;
  logic              unused_wrempty;

  // The FIFO empty flag plays no part in control.
  assign unused_wrempty = wrempty;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key;
      key_sync_q <= key_meta_q;
    end
  end

  assign stab_cnt_d = stab_cnt_q + STAB_W'(1);

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt_q   <= '0;
      key_db_q     <= 1'b1;
      key_db_dly_q <= 1'b1;
    end else begin
      key_db_dly_q <= key_db_q;
      if (key_sync_q != key_db_q) begin
        if (stab_cnt_q == STAB_LAST) begin
          key_db_q   <= key_sync_q;
          stab_cnt_q <= '0;
        end else begin
          stab_cnt_q <= stab_cnt_d;
        end
      end else begin
        stab_cnt_q <= '0;
      end
    end
  end

  // One-cycle press strobe on the falling edge of the debounced level.
  assign press = key_db_dly_q & ~key_db_q;

  // Writes are gated combinationally by wrfull so a full FIFO is never written.
  assign wrreq  = (state_q == S_FILL) & ~wrfull;
  assign data_d = data_q + 8'd1;

  // Burst FSM together with the write-data and burst-length counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      led_q       <= 1'b0;
      data_q      <= 8'd1;
      burst_cnt_q <= 8'd0;
    end else begin
      if (wrreq) begin
        data_q      <= data_d;
        burst_cnt_q <= burst_cnt_q + 8'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (press) begin
            state_q     <= S_FILL;
            led_q       <= 1'b1;
            burst_cnt_q <= 8'd0;
          end
        end
        S_FILL: begin
          // Full truncates the burst; otherwise leave after the last write.
          if (wrfull || (burst_cnt_q == BURST_LAST)) begin
            state_q <= S_HOLD;
            led_q   <= 1'b0;
          end
        end
        S_HOLD: begin
          // Wait for release so a held key cannot start another burst.
          if (key_db_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign data   = data_q;
  assign led_wr = led_q;

endmodule
`default_nettype wire

// File: doc/key_fifo_writer.md
KEY_FIFO_WRITER -- requirements
Module: key_fifo_writer

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 20, is the number of consecutive stable clk cycles required to accept a key level change (20 ms at 1 kHz).
REQ-002 Parameter BURST_LEN, default 16, is the maximum number of FIFO writes per key press (range 1..255).
REQ-003 Port clk, input, 1 bit: the single clock (write-side clock, 1 kHz in the top level); all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port key, input, 1 bit: raw push-button, active low, asynchronous to clk, may bounce.
REQ-006 Port wrfull, input, 1 bit: FIFO write-side full flag.
REQ-007 Port wrempty, input, 1 bit: FIFO write-side empty flag.
REQ-008 Port data, output, 8 bits: FIFO write data.
REQ-009 Port wrreq, output, 1 bit: FIFO write request; a write occurs on each clk edge where wrreq=1.
REQ-010 Port led_wr, output, 1 bit: high while a burst is in progress.

Function
REQ-011 key SHALL pass through a 2-flop synchronizer (reset value 1) before any other use.
REQ-012 Debounced level key_db (reset 1) SHALL change only after the synchronized key has differed from key_db for DEBOUNCE_CYC consecutive cycles; any return to key_db's value clears the stability counter.
REQ-013 A press event SHALL be a 1-to-0 transition of key_db, one cycle wide.
REQ-014 FSM states SHALL be IDLE, FILL and HOLD; reset state is IDLE.
REQ-015 IDLE -> FILL on a press event; otherwise stay.
REQ-016 In FILL, wrreq SHALL equal NOT wrfull, combinationally, so that no write is ever issued while wrfull=1.
REQ-017 wrreq SHALL be 0 in IDLE and HOLD.
REQ-018 The burst counter SHALL clear on entry to FILL and increment on every cycle with wrreq=1.
REQ-019 FILL -> HOLD on the cycle the BURST_LEN-th write is issued, or on any FILL cycle with wrfull=1 (burst truncated, with no retry).
REQ-020 HOLD -> IDLE when key_db=1 (key released); a held key SHALL never start a second burst.
REQ-021 data SHALL be a registered 8-bit value that increments by 1 after each cycle with wrreq=1, wrapping from 255 to 0; it holds otherwise and persists across bursts.
REQ-022 The first value written after reset SHALL be 1, so data resets to 8'd1.
REQ-023 led_wr SHALL be 1 exactly while the state is FILL.
REQ-024 wrempty SHALL be ignored for control; it is present for interface completeness.
REQ-025 A press event arriving while the state is FILL or HOLD SHALL be ignored.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force: state IDLE, wrreq=0, led_wr=0, data=1, burst counter=0, synchronizer and key_db=1, stability counter=0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no further writes; after release, the block waits for a fresh press event.

Verification
REQ-028 Clean press: key held low for 30 cycles with the FIFO empty -> wrreq=1 for exactly 16 consecutive cycles, data values 1..16 written, led_wr high for those 16 cycles, then HOLD until key=1.
REQ-029 Bounce: key toggles every 3 cycles for 15 cycles, then stays low -> no press event until 20 stable low cycles have elapsed; exactly one burst results.
REQ-030 Full truncation: wrfull raised after the 5th write of a burst -> wrreq=0 from that cycle, state HOLD, only 5 writes; next burst starts at data=6.
REQ-031 Wrap: 16 presses (256 writes) -> the 256th written value is 0, and the following burst starts at 1.
REQ-032 Long hold: key held low for 500 cycles -> exactly one burst; release then press again -> a second burst.
REQ-033 Reset mid-burst: rst_n pulsed low after the 7th write -> wrreq drops asynchronously, data=1 after release, and no writes occur until the next debounced press.
